// File: rtl/nap_timer_ctrl_if.sv
// Nap timer control bus.
// Groups the main-FSM request signals and the timer status signals.
//   master : main FSM side   (drives enSleep/enAlarm/enCancel/napMinutes,
//                             observes completeSleep/sleeping/remain*/buzzer)
//   slave  : nap timer side  (the reverse)
interface nap_timer_ctrl_if;
  logic       enSleep;
  logic       enAlarm;
  logic       enCancel;
  logic [6:0] napMinutes;
  logic       completeSleep;
  logic       sleeping;
  logic [6:0] remainMin;
  logic [5:0] remainSec;
  logic       buzzer;

  modport master (
    output enSleep, enAlarm, enCancel, napMinutes,
    input  completeSleep, sleeping, remainMin, remainSec, buzzer
  );

  modport slave (
    input  enSleep, enAlarm, enCancel, napMinutes,
    output completeSleep, sleeping, remainMin, remainSec, buzzer
  );
endinterface

// File: rtl/nap_timer_ctrl.sv
// Nap countdown and alarm buzzer sequencer.
// Loads a clamped nap length (1..99 min) when the main FSM enters sleep,
// counts down in mm:ss using a TICKS_PER_SEC prescaler, raises completeSleep
// at 00:00, and drives a periodic buzzer pattern while the alarm is enabled.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : nap_timer_ctrl_if.slave (enables, napMinutes in; status, time,
//           buzzer out -- all outputs registered)
module nap_timer_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BEEP_PERIOD   = 500,
  parameter int BEEP_ON       = 250
) (
  input  logic              clock,
  input  logic              reset,
  nap_timer_ctrl_if.slave   bus
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BEEP_PERIOD > 2) ? $clog2(BEEP_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE, ALARM} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_q, beep_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          complete_q, complete_d;
  logic          sleeping_q, sleeping_d;
  logic          buzzer_q, buzzer_d;

  // Decremented time, only used on a terminal prescaler tick.
  logic [6:0]    min_dec;
  logic [5:0]    sec_dec;
  logic [BW-1:0] beep_next;

  always_comb begin
    if (sec_q != 6'd0) begin
      sec_dec = sec_q - 6'd1;
      min_dec = min_q;
    end else begin
      sec_dec = 6'd59;
      // Guard against underflow; COUNT never sees 00:00, but stay safe.
      min_dec = (min_q != 7'd0) ? (min_q - 7'd1) : 7'd0;
    end
    beep_next = (beep_q == BW'(BEEP_PERIOD - 1)) ? '0 : (beep_q + 1'b1);
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    beep_d     = beep_q;
    min_d      = min_q;
    sec_d      = sec_q;
    complete_d = complete_q;
    sleeping_d = sleeping_q;
    buzzer_d   = buzzer_q;

    if (bus.enCancel) begin
      state_d    = IDLE;
      presc_d    = '0;
      beep_d     = '0;
      min_d      = '0;
      sec_d      = '0;
      complete_d = 1'b0;
      sleeping_d = 1'b0;
      buzzer_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d    = '0;
          beep_d     = '0;
          min_d      = '0;
          sec_d      = '0;
          complete_d = 1'b0;
          sleeping_d = 1'b0;
          buzzer_d   = 1'b0;
          // enSleep takes precedence over a simultaneous enAlarm.
          if (bus.enSleep) begin
            state_d    = COUNT;
            sleeping_d = 1'b1;
            if (bus.napMinutes == 7'd0)
              min_d = 7'd1;
            else if (bus.napMinutes > 7'd99)
              min_d = 7'd99;
            else
              min_d = bus.napMinutes;
          end
        end

        COUNT: begin
          if (!bus.enSleep) begin
            state_d    = IDLE;
            presc_d    = '0;
            min_d      = '0;
            sec_d      = '0;
            sleeping_d = 1'b0;
            complete_d = 1'b0;
          end else if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
            presc_d = '0;
            min_d   = min_dec;
            sec_d   = sec_dec;
            // The tick that lands on 00:00 finishes the nap on the same edge.
            if (min_dec == 7'd0 && sec_dec == 6'd0) begin
              state_d    = DONE;
              complete_d = 1'b1;
              sleeping_d = 1'b0;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end

        DONE: begin
          complete_d = 1'b1;
          if (bus.enAlarm) begin
            state_d    = ALARM;
            complete_d = 1'b0;
            beep_d     = '0;
            buzzer_d   = 1'b1;
          end else if (!bus.enSleep) begin
            state_d    = IDLE;
            complete_d = 1'b0;
          end
        end

        ALARM: begin
          if (!bus.enAlarm) begin
            state_d  = IDLE;
            beep_d   = '0;
            buzzer_d = 1'b0;
          end else begin
            // Buzzer follows the counter value being loaded, so the pattern
            // starts high on the first ALARM cycle.
            beep_d   = beep_next;
            buzzer_d = (beep_next < BW'(BEEP_ON));
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      beep_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      complete_q <= 1'b0;
      sleeping_q <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      beep_q     <= beep_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      complete_q <= complete_d;
      sleeping_q <= sleeping_d;
      buzzer_q   <= buzzer_d;
    end
  end

  assign bus.completeSleep = complete_q;
  assign bus.sleeping      = sleeping_q;
  assign bus.remainMin     = min_q;
  assign bus.remainSec     = sec_q;
  assign bus.buzzer        = buzzer_q;

endmodule

// File: doc/nap_timer_ctrl.md
Name: nap_timer_ctrl

Overview:
- Sequences the nap countdown and the alarm buzzer on behalf of the main state machine.
- While the main FSM asserts enSleep, the block loads the nap length, counts down in mm:ss and returns completeSleep to the main FSM.
- While the main FSM asserts enAlarm, it drives a periodic buzzer pattern.
- It also exports the remaining time for the display.

Parameters:
- TICKS_PER_SEC, 1000: clock cycles per countdown second (prescaler terminal count + 1); must be ≥2.
- BEEP_PERIOD, 500: buzzer pattern period in clock cycles; must be ≥2.
- BEEP_ON, 250: cycles per period with the buzzer high; must satisfy 1 ≤ BEEP_ON < BEEP_PERIOD.

Ports:
- clock  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clock).
- enSleep  in  1  main FSM sleep-state enable.
- enAlarm  in  1  main FSM alarm-state enable.
- enCancel  in  1  main FSM cancel-state enable.
- napMinutes  in  7  requested nap length in minutes, sampled at load.
- completeSleep  out  1  countdown reached 00:00; level.
- sleeping  out  1  countdown in progress.
- remainMin  out  7  remaining minutes, 0..99.
- remainSec  out  6  remaining seconds, 0..59.
- buzzer  out  1  alarm sounder drive.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a rising edge) forces:
  - state IDLE
  - completeSleep=0, sleeping=0, buzzer=0
  - remainMin=0, remainSec=0
  - prescaler=0, beep counter=0
- Reset applies in every state, including mid-countdown and mid-alarm.
- Priority at each edge: reset > enCancel > state logic.
- enCancel=1 in any state: next state IDLE, all outputs cleared as on reset.
- States are IDLE, COUNT, DONE, ALARM.
- IDLE:
  - Outputs low/zero.
  - enSleep=1 → COUNT; sleeping=1; prescaler=0; remainSec=0.
  - remainMin is loaded with the clamped napMinutes: 0 → 1; >99 → 99; otherwise the value unchanged.
  - napMinutes is ignored outside this load edge.
- COUNT:
  - The prescaler increments every cycle.
  - When prescaler==TICKS_PER_SEC-1 it wraps to 0 and the time decrements:
    - remainSec>0: remainSec-1.
    - remainSec==0: remainSec=59, remainMin-1.
  - The decrement that produces 00:00 moves the state to DONE on the same edge, with completeSleep=1 and sleeping=0.
  - Total latency is load edge E0 → completeSleep high after edge E0 + N·60·TICKS_PER_SEC, where N is the clamped minutes.
  - enSleep=0 (with enCancel=0) → IDLE, outputs cleared; this is an abort.
- DONE:
  - completeSleep is held at 1 and time holds at 00:00.
  - enAlarm=1 → ALARM, completeSleep=0, beep counter=0, buzzer=1.
  - enSleep=0 and enAlarm=0 → IDLE.
- ALARM:
  - The beep counter increments and wraps at BEEP_PERIOD-1 back to 0.
  - buzzer = (next counter value < BEEP_ON).
  - The buzzer is therefore high for the first BEEP_ON cycles of every period, beginning with the first ALARM cycle.
  - enAlarm=0 → IDLE, buzzer=0.
- Simultaneous enSleep and enAlarm in IDLE: enSleep wins.
- enAlarm in IDLE or COUNT is ignored.
- The prescaler never exceeds TICKS_PER_SEC-1; remainMin never underflows.

Test Plan (TICKS_PER_SEC=4, BEEP_PERIOD=6, BEEP_ON=2):
- Reset: hold reset=0 for 2 cycles with enSleep=1 → all outputs 0, state IDLE. Release; enSleep=1, napMinutes=1 → remainMin=1/remainSec=0, sleeping=1; after 4 cycles 00:59; completeSleep=1 exactly 240 cycles after load.
- Clamping: napMinutes=0 → remainMin=1. napMinutes=120 → remainMin=99. Changing napMinutes during COUNT leaves the time unchanged.
- Minute borrow: napMinutes=2; after 4 cycles → 01:59. After 240 cycles → 00:59 → then 00:58. No underflow at 00:00; DONE is held while enSleep=1.
- Alarm pattern: from DONE raise enAlarm → completeSleep=0; buzzer sequence 1,1,0,0,0,0,1,1,... Drop enAlarm → buzzer=0 and IDLE next cycle.
- Aborts: enCancel=1 at 00:30 → next cycle all outputs 0. enSleep drop mid-COUNT → IDLE. reset=0 during ALARM → buzzer=0 on that edge.
- Simultaneous: enSleep=1 and enAlarm=1 in IDLE → COUNT. enCancel=1 together with a terminal prescaler tick at 00:01 → IDLE, completeSleep stays 0.
